// File: rtl/idex_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : idex_hazard_unit
// Purpose  : Load-use stall and branch/jump flush control for IF/ID and ID/EX,
//            with saturating stall/flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
module idex_hazard_unit #(
  parameter int REG_W        = 5,
  parameter int LOAD_STALL   = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [1:0]       ex_mem_read,
  input  logic [REG_W-1:0] ex_write_reg,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] c_st_run   = 2'd0;
  localparam logic [1:0] c_st_stall = 2'd1;
  localparam logic [1:0] c_st_flush = 2'd2;

  localparam logic [2:0] c_load_rem  = 3'(LOAD_STALL - 1);
  localparam logic [2:0] c_flush_rem = 3'(FLUSH_CYCLES - 1);

  logic [1:0]       r_state;
  logic [2:0]       r_rem;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic             w_redirect;
  logic             w_hazard;
  logic [1:0]       w_state_nxt;
  logic [2:0]       w_rem_nxt;
  logic             w_stall_inc;
  logic             w_flush_inc;
  logic             w_pc_write;
  logic             w_ifid_write;
  logic             w_ifid_flush;
  logic             w_idex_bubble;

  assign w_redirect = ex_branch_taken | ex_jump;

  // Register 0 is hardwired, so a load targeting it can never feed a consumer.
  assign w_hazard = (ex_mem_read != 2'b00) && (ex_write_reg != '0) &&
                    ((id_uses_rs && (id_rs == ex_write_reg)) ||
                     (id_uses_rt && (id_rt == ex_write_reg)));

  always_comb begin
    w_state_nxt   = r_state;
    w_rem_nxt     = r_rem;
    w_stall_inc   = 1'b0;
    w_flush_inc   = 1'b0;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;

    if (w_redirect) begin
      // A redirect wins in every state and restarts the flush window.
      w_ifid_flush  = 1'b1;
      w_idex_bubble = 1'b1;
      w_flush_inc   = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt = c_st_flush;
        w_rem_nxt   = c_flush_rem;
      end else begin
        w_state_nxt = c_st_run;
        w_rem_nxt   = 3'd0;
      end
    end else if (r_state == c_st_stall || r_state == c_st_flush) begin
      if (r_state == c_st_stall) begin
        w_pc_write    = 1'b0;
        w_ifid_write  = 1'b0;
        w_idex_bubble = 1'b1;
      end else begin
        w_ifid_flush  = 1'b1;
        w_idex_bubble = 1'b1;
      end
      if (r_rem <= 3'd1) begin
        w_state_nxt = c_st_run;
        w_rem_nxt   = 3'd0;
      end else begin
        w_rem_nxt = r_rem - 3'd1;
      end
    end else if (w_hazard) begin
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_idex_bubble = 1'b1;
      w_stall_inc   = 1'b1;
      if (LOAD_STALL > 1) begin
        w_state_nxt = c_st_stall;
        w_rem_nxt   = c_load_rem;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_run;
      r_rem       <= 3'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      if (w_stall_inc && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_flush_inc && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  // Reset holds the front end frozen and the pipeline filled with bubbles.
  assign pc_write    = rst_n & w_pc_write;
  assign ifid_write  = rst_n & w_ifid_write;
  assign ifid_flush  = ~rst_n | w_ifid_flush;
  assign idex_bubble = ~rst_n | w_idex_bubble;
  assign state       = r_state;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_idex_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_idex_hazard_unit
// Purpose  : Directed bench for idex_hazard_unit, default and extended configs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idex_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_write_reg;
  logic       id_uses_rs, id_uses_rt, ex_branch_taken, ex_jump;
  logic [1:0] ex_mem_read;

  logic        a_pc, a_ifw, a_flush, a_bub;
  logic [1:0]  a_state;
  logic [15:0] a_scnt, a_fcnt;
  logic        b_pc, b_ifw, b_flush, b_bub;
  logic [1:0]  b_state;
  logic [3:0]  b_scnt, b_fcnt;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  idex_hazard_unit dut_a (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_write_reg(ex_write_reg), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .pc_write(a_pc), .ifid_write(a_ifw), .ifid_flush(a_flush), .idex_bubble(a_bub),
    .state(a_state), .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
  );

  idex_hazard_unit #(.REG_W(5), .LOAD_STALL(3), .FLUSH_CYCLES(2), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_write_reg(ex_write_reg), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
    .pc_write(b_pc), .ifid_write(b_ifw), .ifid_flush(b_flush), .idex_bubble(b_bub),
    .state(b_state), .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_mem_read = 2'b00; ex_write_reg = 5'd0; ex_branch_taken = 1'b0; ex_jump = 1'b0;
  endtask

  task automatic load_use_rs8();
    clear_in();
    ex_mem_read = 2'b01; ex_write_reg = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
  endtask

  initial begin
    // Reset with a hazard present on the inputs
    rst_n = 1'b0;
    load_use_rs8();
    #2;
    check("rst_a_pc", 32'(a_pc), 0);
    check("rst_a_ifw", 32'(a_ifw), 0);
    check("rst_a_flush", 32'(a_flush), 1);
    check("rst_a_bub", 32'(a_bub), 1);
    check("rst_b_state", 32'(b_state), 0);

    cyc();
    rst_n = 1'b1;
    clear_in();
    #1;
    check("run_a_pc", 32'(a_pc), 1);
    check("run_a_ifw", 32'(a_ifw), 1);
    check("run_a_flush", 32'(a_flush), 0);
    check("run_a_bub", 32'(a_bub), 0);
    check("run_a_scnt", 32'(a_scnt), 0);
    check("run_a_fcnt", 32'(a_fcnt), 0);

    // Load-use on rs
    load_use_rs8();
    #1;
    check("lu_a_pc", 32'(a_pc), 0);
    check("lu_a_ifw", 32'(a_ifw), 0);
    check("lu_a_bub", 32'(a_bub), 1);
    check("lu_a_flush", 32'(a_flush), 0);
    check("lu_b_state0", 32'(b_state), 0);
    cyc();
    clear_in();
    #1;
    check("lu_a_pc_after", 32'(a_pc), 1);
    check("lu_a_bub_after", 32'(a_bub), 0);
    check("lu_a_state", 32'(a_state), 0);
    check("lu_a_scnt", 32'(a_scnt), 1);
    check("lu_b_state1", 32'(b_state), 1);
    check("lu_b_pc1", 32'(b_pc), 0);
    check("lu_b_scnt", 32'(b_scnt), 1);
    cyc();
    #1;
    check("lu_b_state2", 32'(b_state), 1);
    check("lu_b_pc2", 32'(b_pc), 0);
    cyc();
    #1;
    check("lu_b_state3", 32'(b_state), 0);
    check("lu_b_pc3", 32'(b_pc), 1);
    check("lu_b_scnt3", 32'(b_scnt), 1);

    // Non-hazards
    clear_in();
    ex_mem_read = 2'b01; ex_write_reg = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    #1;
    check("nh_r0_a_pc", 32'(a_pc), 1);
    check("nh_r0_b_pc", 32'(b_pc), 1);
    cyc();
    clear_in();
    ex_mem_read = 2'b01; ex_write_reg = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b0;
    #1;
    check("nh_rtunused_a_pc", 32'(a_pc), 1);
    cyc();
    clear_in();
    ex_mem_read = 2'b00; ex_write_reg = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
    #1;
    check("nh_noload_a_pc", 32'(a_pc), 1);
    check("nh_noload_a_bub", 32'(a_bub), 0);
    cyc();

    // Load-use on rt
    clear_in();
    ex_mem_read = 2'b10; ex_write_reg = 5'd8; id_rt = 5'd8; id_uses_rt = 1'b1;
    #1;
    check("rt_a_ifw", 32'(a_ifw), 0);
    cyc();
    clear_in();
    #1;
    check("rt_a_scnt", 32'(a_scnt), 2);
    cyc();
    cyc();
    check("rt_b_state", 32'(b_state), 0);
    check("rt_b_scnt", 32'(b_scnt), 2);

    // Branch taken together with a hazard
    load_use_rs8();
    ex_branch_taken = 1'b1;
    #1;
    check("br_a_flush", 32'(a_flush), 1);
    check("br_a_bub", 32'(a_bub), 1);
    check("br_a_pc", 32'(a_pc), 1);
    check("br_a_ifw", 32'(a_ifw), 1);
    check("br_b_flush", 32'(b_flush), 1);
    cyc();
    clear_in();
    #1;
    check("br_a_state", 32'(a_state), 0);
    check("br_a_flush_after", 32'(a_flush), 0);
    check("br_a_fcnt", 32'(a_fcnt), 1);
    check("br_a_scnt", 32'(a_scnt), 2);
    check("br_b_state", 32'(b_state), 2);
    check("br_b_flush2", 32'(b_flush), 1);
    check("br_b_bub2", 32'(b_bub), 1);
    check("br_b_pc2", 32'(b_pc), 1);
    check("br_b_fcnt", 32'(b_fcnt), 1);
    check("br_b_scnt", 32'(b_scnt), 2);
    cyc();
    #1;
    check("br_b_state_end", 32'(b_state), 0);
    check("br_b_flush_end", 32'(b_flush), 0);

    // Jump arriving during a stall aborts it
    load_use_rs8();
    #1;
    cyc();
    clear_in();
    ex_jump = 1'b1;
    #1;
    check("js_b_state", 32'(b_state), 1);
    check("js_b_pc", 32'(b_pc), 1);
    check("js_b_flush", 32'(b_flush), 1);
    cyc();
    clear_in();
    #1;
    check("js_b_state2", 32'(b_state), 2);
    check("js_b_fcnt", 32'(b_fcnt), 2);
    check("js_b_scnt", 32'(b_scnt), 3);
    check("js_a_fcnt", 32'(a_fcnt), 2);
    check("js_a_scnt", 32'(a_scnt), 3);
    cyc();
    check("js_b_state3", 32'(b_state), 0);

    // Saturation: 17 more hazard events
    for (int i = 0; i < 17; i++) begin
      load_use_rs8();
      #1;
      cyc();
      clear_in();
      cyc();
      cyc();
    end
    check("sat_b_scnt", 32'(b_scnt), 15);
    check("sat_a_scnt", 32'(a_scnt), 20);
    load_use_rs8();
    #1;
    cyc();
    clear_in();
    #1;
    check("sat_b_state", 32'(b_state), 1);
    check("sat_b_held", 32'(b_scnt), 15);
    check("sat_a_scnt2", 32'(a_scnt), 21);

    // Asynchronous reset mid-stall
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_b_state", 32'(b_state), 0);
    check("ar_b_scnt", 32'(b_scnt), 0);
    check("ar_b_fcnt", 32'(b_fcnt), 0);
    check("ar_a_scnt", 32'(a_scnt), 0);
    check("ar_a_fcnt", 32'(a_fcnt), 0);
    check("ar_b_pc", 32'(b_pc), 0);
    check("ar_b_flush", 32'(b_flush), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
